// File: rtl/mem_sram_ctrl_pkg.sv
// Shared definitions for the memory-stage SRAM controller: FSM state
// encoding and external SRAM geometry.
package mem_sram_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOW  = 3'd1,
    S_HIGH = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam int unsigned ADDR_W = 18;
  localparam int unsigned DQ_W   = 16;

endpackage

// File: rtl/sram_settle_counter.sv
// Loadable 3-bit down-counter with a zero flag, used to time the idle
// bus cycles that follow the two halfword accesses.
module sram_settle_counter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [2:0] load_val_i,
  input  logic       dec_i,
  output logic       zero_o
);

  logic [2:0] cnt_q;

  // Load takes priority over decrement; decrement saturates at zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != 3'd0)) begin
      cnt_q <= cnt_q - 3'd1;
    end
  end

  assign zero_o = (cnt_q == 3'd0);

endmodule

// File: rtl/mem_sram_ctrl.sv
// Memory-stage SRAM controller: splits a 32-bit word load/store into two
// 16-bit accesses on an external 256Kx16 SRAM, freezing the pipeline via
// Ready until the access sequence reaches DONE.
module mem_sram_ctrl
  import mem_sram_ctrl_pkg::*;
#(
  parameter int unsigned BASE_ADDR     = 1024,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                WR_EN,
  input  logic                RD_EN,
  input  logic [31:0]         Address,
  input  logic [31:0]         Write_Data,
  output logic [31:0]         Read_Data,
  output logic                Ready,
  output logic [ADDR_W-1:0]   SRAM_ADDR,
  input  logic [DQ_W-1:0]     SRAM_DQ_In,
  output logic [DQ_W-1:0]     SRAM_DQ_Out,
  output logic                SRAM_DQ_OE,
  output logic                SRAM_WE_N,
  output logic                SRAM_OE_N,
  output logic                SRAM_CE_N,
  output logic                SRAM_UB_N,
  output logic                SRAM_LB_N
);

  // The counter is loaded with SETTLE_CYCLES-1 so that WAIT lasts exactly
  // SETTLE_CYCLES cycles (exit on the cycle the counter reads zero).
  localparam logic [2:0] SETTLE_LOAD =
    (SETTLE_CYCLES > 0) ? 3'(SETTLE_CYCLES - 1) : 3'd0;

  state_e              state_q;
  logic [ADDR_W-2:0]   widx_q;
  logic                wr_q;
  logic [31:0]         wdata_q;
  logic [DQ_W-1:0]     lo_q;
  logic [31:0]         rdata_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_n_q;
  logic                oe_n_q;
  logic                dq_oe_q;
  logic [DQ_W-1:0]     dq_out_q;

  logic [31:0]         offs;
  logic [ADDR_W-2:0]   widx;
  logic                unused_offs;
  logic                req;
  logic                cnt_zero;

  assign offs        = Address - BASE_ADDR;
  assign widx        = offs[ADDR_W:2];
  assign unused_offs = ^{offs[31:ADDR_W+1], offs[1:0]};
  assign req         = WR_EN | RD_EN;

  sram_settle_counter u_settle (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (state_q == S_HIGH),
    .load_val_i (SETTLE_LOAD),
    .dec_i      (state_q == S_WAIT),
    .zero_o     (cnt_zero)
  );

  // Access sequencer; SRAM strobes are registered alongside the state so
  // they reflect the state being entered and never the raw request inputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      widx_q   <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      lo_q     <= '0;
      rdata_q  <= '0;
      addr_q   <= '0;
      we_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      dq_oe_q  <= 1'b0;
      dq_out_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            state_q  <= S_LOW;
            widx_q   <= widx;
            wr_q     <= WR_EN;
            wdata_q  <= Write_Data;
            addr_q   <= {widx, 1'b0};
            we_n_q   <= ~WR_EN;
            oe_n_q   <= WR_EN;
            dq_oe_q  <= WR_EN;
            dq_out_q <= WR_EN ? Write_Data[15:0] : '0;
          end
        end
        S_LOW: begin
          state_q  <= S_HIGH;
          if (!wr_q) lo_q <= SRAM_DQ_In;
          addr_q   <= {widx_q, 1'b1};
          dq_out_q <= wr_q ? wdata_q[31:16] : '0;
        end
        S_HIGH: begin
          state_q  <= (SETTLE_CYCLES != 0) ? S_WAIT : S_DONE;
          if (!wr_q) rdata_q <= {SRAM_DQ_In, lo_q};
          addr_q   <= '0;
          we_n_q   <= 1'b1;
          oe_n_q   <= 1'b1;
          dq_oe_q  <= 1'b0;
          dq_out_q <= '0;
        end
        S_WAIT: begin
          if (cnt_zero) state_q <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign Ready       = ~req | (state_q == S_DONE);
  assign Read_Data   = rdata_q;
  assign SRAM_ADDR   = addr_q;
  assign SRAM_DQ_Out = dq_out_q;
  assign SRAM_DQ_OE  = dq_oe_q;
  assign SRAM_WE_N   = we_n_q;
  assign SRAM_OE_N   = oe_n_q;
  assign SRAM_CE_N   = 1'b0;
  assign SRAM_UB_N   = 1'b0;
  assign SRAM_LB_N   = 1'b0;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl: three instances (SETTLE_CYCLES 2, 0, 7)
// share stimulus, each with its own small SRAM model.
module tb_mem_sram_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        WR_EN = 1'b0;
  logic        RD_EN = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] Write_Data = '0;

  logic [31:0] rdata  [3];
  logic        ready  [3];
  logic [17:0] saddr  [3];
  logic [15:0] dq_in  [3];
  logic [15:0] dq_out [3];
  logic        dq_oe  [3];
  logic        we_n   [3];
  logic        oe_n   [3];
  logic        ce_n   [3];
  logic        ub_n   [3];
  logic        lb_n   [3];

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned SC = (g == 0) ? 2 : (g == 1) ? 0 : 7;
    logic [15:0] mem [0:63];

    mem_sram_ctrl #(.BASE_ADDR(1024), .SETTLE_CYCLES(SC)) u_dut (
      .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .RD_EN(RD_EN),
      .Address(Address), .Write_Data(Write_Data),
      .Read_Data(rdata[g]), .Ready(ready[g]), .SRAM_ADDR(saddr[g]),
      .SRAM_DQ_In(dq_in[g]), .SRAM_DQ_Out(dq_out[g]), .SRAM_DQ_OE(dq_oe[g]),
      .SRAM_WE_N(we_n[g]), .SRAM_OE_N(oe_n[g]), .SRAM_CE_N(ce_n[g]),
      .SRAM_UB_N(ub_n[g]), .SRAM_LB_N(lb_n[g])
    );

    always @(posedge CLK) if (we_n[g] === 1'b0) mem[saddr[g][5:0]] <= dq_out[g];
    assign dq_in[g] = (oe_n[g] === 1'b0) ? mem[saddr[g][5:0]] : 16'h0000;
  end

  // Per-cycle record of one access, index 0 = request cycle.
  logic [17:0] r_addr [0:47];
  logic [15:0] r_out  [0:47];
  logic        r_we   [0:47];
  logic        r_oe   [0:47];
  logic        r_dqoe [0:47];
  logic [31:0] r_rd   [0:47];
  int n_cyc, stall_n, we_lo, oe_lo;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at #1 after a rising edge; raises the request and records until
  // Ready goes high, then drops the request #1 after the next edge.
  task automatic access(input logic wr, input logic rd, input logic [31:0] a,
                        input logic [31:0] wd, input int d);
    bit done = 0;
    WR_EN = wr; RD_EN = rd; Address = a; Write_Data = wd;
    n_cyc = 0; we_lo = 0; oe_lo = 0;
    while (!done && n_cyc < 40) begin
      @(negedge CLK);
      r_addr[n_cyc] = saddr[d]; r_out[n_cyc] = dq_out[d];
      r_we[n_cyc] = we_n[d]; r_oe[n_cyc] = oe_n[d];
      r_dqoe[n_cyc] = dq_oe[d]; r_rd[n_cyc] = rdata[d];
      if (we_n[d] === 1'b0) we_lo++;
      if (oe_n[d] === 1'b0) oe_lo++;
      if (ready[d] === 1'b1) done = 1;
      n_cyc++;
    end
    if (!done) chk("ready_timeout", 32'd0, 32'd1);
    stall_n = n_cyc - 1;
    @(posedge CLK); #1;
    WR_EN = 1'b0; RD_EN = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    int viol;

    // Power-on reset
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_rdata", rdata[0], 32'h0);
    chk("rst_bus", {14'h0, saddr[0], we_n[0], oe_n[0], dq_oe[0]}, 32'h6);
    chk("rst_dqout", {16'h0, dq_out[0]}, 32'h0);
    chk("rst_ready", {31'h0, ready[0]}, 32'h1);
    chk("tied_low", {29'h0, ce_n[0], ub_n[0], lb_n[0]}, 32'h0);
    @(posedge CLK); #1; RST = 1'b0;

    // Asynchronous reset during the LOW half of a store
    idle(1);
    WR_EN = 1'b1; Address = 32'd1032; Write_Data = 32'h11112222;
    @(posedge CLK); #2;
    chk("midrst_pre_we", {31'h0, we_n[0]}, 32'h0);
    RST = 1'b1; #1;
    chk("midrst_we_oe", {30'h0, we_n[0], dq_oe[0]}, 32'h2);
    chk("midrst_addr", {14'h0, saddr[0]}, 32'h0);
    WR_EN = 1'b0;
    @(posedge CLK); #1; RST = 1'b0;
    @(negedge CLK);
    chk("midrst_ready", {31'h0, ready[0]}, 32'h1);
    chk("midrst_rdata", rdata[0], 32'h0);

    // Ten cycles with no request: Ready high, bus quiet
    viol = 0;
    repeat (10) begin
      @(negedge CLK);
      if (ready[0] !== 1'b1 || we_n[0] !== 1'b1 || oe_n[0] !== 1'b1 ||
          dq_oe[0] !== 1'b0 || saddr[0] !== 18'h0) viol++;
    end
    chk("idle_quiet", viol, 0);
    @(posedge CLK); #1;

    // Store 0xDEADBEEF to 1024+8 -> halfwords 4 and 5
    access(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 0);
    chk("st_stall", stall_n, 5);
    chk("st_lo", {r_addr[1][15:0], r_out[1]}, 32'h0004BEEF);
    chk("st_hi", {r_addr[2][15:0], r_out[2]}, 32'h0005DEAD);
    chk("st_lo_strobes", {29'h0, r_we[1], r_oe[1], r_dqoe[1]}, 32'h3);
    chk("st_we_cycles", we_lo, 2);
    chk("st_oe_cycles", oe_lo, 0);
    chk("st_done_quiet", {13'h0, r_addr[n_cyc-1], r_we[n_cyc-1]}, 32'h1);
    chk("st_rdata_kept", r_rd[n_cyc-1], 32'h0);

    // Load back from 1032
    idle(2);
    access(1'b0, 1'b1, 32'd1032, 32'h0, 0);
    chk("ld_stall", stall_n, 5);
    chk("ld_addr", {r_addr[1][15:0], r_addr[2][15:0]}, 32'h00040005);
    chk("ld_lo_strobes", {29'h0, r_we[1], r_oe[1], r_dqoe[1]}, 32'h4);
    chk("ld_we_cycles", we_lo, 0);
    chk("ld_rdata_in_high", r_rd[2], 32'h0);
    chk("ld_rdata_wait", r_rd[3], 32'hDEADBEEF);
    chk("ld_rdata_done", r_rd[n_cyc-1], 32'hDEADBEEF);

    // Back-to-back: store to 1024 then load from 1024 in the cycle after DONE
    idle(1);
    access(1'b1, 1'b0, 32'd1024, 32'h12345678, 0);
    chk("b2b_st_stall", stall_n, 5);
    chk("b2b_st_addr", {r_addr[1][15:0], r_addr[2][15:0]}, 32'h00000001);
    access(1'b0, 1'b1, 32'd1024, 32'h0, 0);
    chk("b2b_ld_stall", stall_n, 5);
    chk("b2b_ld_data", r_rd[n_cyc-1], 32'h12345678);

    // Both enables: write wins, Read_Data untouched
    idle(1);
    access(1'b1, 1'b1, 32'd1036, 32'hA5A55A5A, 0);
    chk("both_we_cycles", we_lo, 2);
    chk("both_hi", {r_addr[2][15:0], r_out[2]}, 32'h0007A5A5);
    chk("both_rdata_kept", r_rd[n_cyc-1], 32'h12345678);
    idle(1);
    access(1'b0, 1'b1, 32'd1036, 32'h0, 0);
    chk("both_readback", r_rd[n_cyc-1], 32'hA5A55A5A);

    // Misaligned address: low two bits ignored
    idle(1);
    access(1'b0, 1'b1, 32'd1027, 32'h0, 0);
    chk("misalign_addr", {14'h0, r_addr[1]}, 32'h0);
    chk("misalign_data", r_rd[n_cyc-1], 32'h12345678);

    // SETTLE_CYCLES = 0 instance
    RST = 1'b1; idle(2); RST = 1'b0; idle(1);
    access(1'b1, 1'b0, 32'd1040, 32'hCAFEF00D, 1);
    chk("s0_st_stall", stall_n, 3);
    idle(1);
    access(1'b0, 1'b1, 32'd1040, 32'h0, 1);
    chk("s0_ld_stall", stall_n, 3);
    chk("s0_ld_data", r_rd[n_cyc-1], 32'hCAFEF00D);

    // SETTLE_CYCLES = 7 instance
    RST = 1'b1; idle(2); RST = 1'b0; idle(1);
    access(1'b1, 1'b0, 32'd1044, 32'h0BADC0DE, 2);
    chk("s7_st_stall", stall_n, 10);
    idle(1);
    access(1'b0, 1'b1, 32'd1044, 32'h0, 2);
    chk("s7_ld_stall", stall_n, 10);
    viol = 0;
    for (int i = 3; i < n_cyc; i++) if (r_rd[i] !== 32'h0BADC0DE) viol++;
    chk("s7_rdata_stable", viol, 0);
    chk("s7_wait_quiet", {30'h0, r_we[5], r_oe[5]}, 32'h3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
